// File: rtl/alu_add_stage_pkg.sv
// Shared ALU definitions: opcode encoding and operand helpers used by the
// decode logic and by the add/subtract pipeline stage.
package alu_add_stage_pkg;

    localparam int OP_BITS = 2;

    typedef enum logic [OP_BITS-1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_ADC = 2'd2,
        OP_SBC = 2'd3
    } alu_op_e;

    // Subtract-type opcodes feed the adder with the one's complement of B.
    function automatic logic op_inverts_b(input alu_op_e op);
        return (op == OP_SUB) || (op == OP_SBC);
    endfunction

endpackage

// File: rtl/rbcla_adder.sv
// Ripple-block carry-lookahead adder: carries are looked ahead inside each
// block of bits_per_block bits and rippled from block to block.
module rbcla_adder #(
    parameter int width          = 8,
    parameter int bits_per_block = 4
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             cin,
    output logic [width-1:0] sum,
    output logic             cout
);

    logic [width-1:0] gen;
    logic [width-1:0] prop;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Per-bit carries from the group generate/propagate of the enclosing block.
    always_comb begin : carry_chain
        logic [width:0] c;
        logic           grp_g;
        logic           grp_p;
        // NOTE: every variable gets a value before any branch so no latch is inferred.
        c     = '0;
        grp_g = 1'b0;
        grp_p = 1'b1;
        c[0]  = cin;
        for (int i = 0; i < width; i++) begin
            if (i % bits_per_block == 0) begin
                grp_g = 1'b0;
                grp_p = 1'b1;
            end
            grp_g    = gen[i] | (prop[i] & grp_g);
            grp_p    = grp_p & prop[i];
            c[i + 1] = grp_g | (grp_p & c[i - (i % bits_per_block)]);
        end
        sum  = prop ^ c[width-1:0];
        cout = c[width];
    end

endmodule

// File: rtl/alu_add_stage.sv
// Two-stage add/subtract pipeline with valid/ready handshakes on both sides.
// S1 registers the operands (B already complemented for subtracts), the adder
// sits between S1 and S2, and S2 registers the result, flags and carry_flag.
module alu_add_stage
    import alu_add_stage_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_BLOCK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_c,
    output logic             out_z,
    output logic             out_n,
    output logic             out_v
);

    logic             s1_valid;
    alu_op_e          s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    logic             carry_flag;
    logic             s2_adv;
    logic             s1_adv;
    logic             in_fire;
    logic             adder_cin;
    logic [WIDTH-1:0] adder_sum;
    logic             adder_cout;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_adv;
    assign in_ready = !s1_valid || s2_adv;
    assign in_fire  = in_valid && in_ready;

    // Carry-in select: chained ops pick up the carry of the last computed result.
    always_comb begin
        adder_cin = carry_flag;
        case (s1_op)
            OP_ADD:  adder_cin = 1'b0;
            OP_SUB:  adder_cin = 1'b1;
            default: adder_cin = carry_flag;
        endcase
    end

    rbcla_adder #(
        .width          (WIDTH),
        .bits_per_block (BITS_PER_BLOCK)
    ) u_adder (
        .a    (s1_a),
        .b    (s1_b),
        .cin  (adder_cin),
        .sum  (adder_sum),
        .cout (adder_cout)
    );

    // S1 occupancy: fill on accept, empty when the entry moves on with no refill.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            s1_valid <= 1'b0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // S1 operand capture; B is complemented here so the adder only ever adds.
    always_ff @(posedge clk) begin
        // NOTE: payload registers are qualified by s1_valid, so they carry no reset.
        if (in_fire) begin
            s1_op <= alu_op_e'(in_op);
            s1_a  <= in_a;
            s1_b  <= op_inverts_b(alu_op_e'(in_op)) ? ~in_b : in_b;
        end
    end

    // S2 result register: loads only when S2 advances, otherwise holds for the consumer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_sum    <= '0;
            out_c      <= 1'b0;
            out_z      <= 1'b0;
            out_n      <= 1'b0;
            out_v      <= 1'b0;
            carry_flag <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sum    <= adder_sum;
                out_c      <= adder_cout;
                out_z      <= (adder_sum == '0);
                out_n      <= adder_sum[WIDTH-1];
                out_v      <= (s1_a[WIDTH-1] == s1_b[WIDTH-1]) &&
                              (adder_sum[WIDTH-1] != s1_a[WIDTH-1]);
                carry_flag <= adder_cout;
            end
        end
    end

endmodule
